// File: rtl/conv3x3_pe_ctrl.sv
// 3x3 conv PE sequencer: loads one filter word, then streams out_w*out_h row-major windows; results queue in a credit-guarded FIFO.
// Window to out_valid is PE_LAT+2 cycles; win_req is withheld while FIFO entries plus in-flight tags reach FIFO_DEPTH. Define CONV_CTRL_RELU_EN to clamp negative psum lanes.
module conv3x3_pe_ctrl #(
  parameter int N          = 1,
  parameter int PE_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        cfg_out_w,
  input  logic [7:0]        cfg_out_h,
  output logic              busy,
  output logic              done,
  output logic              w_req,
  input  logic              w_valid,
  input  logic [72*N-1:0]   w_data,
  output logic              win_req,
  output logic [ADDR_W-1:0] win_addr,
  input  logic              win_valid,
  input  logic [72*N-1:0]   win_data,
  output logic              pe_wb_write_en,
  output logic [72*N-1:0]   pe_filter,
  output logic [72*N-1:0]   pe_ifmap,
  input  logic [16*N-1:0]   pe_psum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [16*N-1:0]   out_data,
  output logic [ADDR_W-1:0] out_idx
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_WFETCH, S_WLOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [15:0]       r_total;
  logic [ADDR_W-1:0] r_addr;
  logic              r_cool;
  logic [72*N-1:0]   r_filter, r_ifmap;
  logic [PE_LAT:0]   r_pipe_vld;
  logic [ADDR_W-1:0] r_pipe_idx [PE_LAT+1];
  logic [16*N-1:0]   r_fifo_dat [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifo_idx [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_accept, w_last, w_credit, w_push, w_pop;
  logic [31:0]       w_inflight;
  logic [16*N-1:0]   w_psum;

  always_comb begin
    w_inflight = 32'd0;
    for (int i = 0; i <= PE_LAT; i++) w_inflight = w_inflight + 32'(r_pipe_vld[i]);
  end

  // Entries already queued plus tags still in the PE pipe must leave room for one more result.
  assign w_credit  = (32'(r_count) + w_inflight) < 32'(FIFO_DEPTH);
  assign win_req   = (r_state == S_STREAM) && !r_cool && w_credit;
  assign w_accept  = win_req && win_valid;
  assign w_last    = (32'(r_addr) + 32'd1) == 32'(r_total);
  assign w_push    = r_pipe_vld[PE_LAT];
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;

  assign win_addr  = r_addr;
  assign pe_filter = r_filter;
  assign pe_ifmap  = r_ifmap;
  assign out_data  = out_valid ? r_fifo_dat[r_rd_ptr] : '0;
  assign out_idx   = out_valid ? r_fifo_idx[r_rd_ptr] : '0;

  always_comb begin
    w_next         = r_state;
    busy           = 1'b1;
    done           = 1'b0;
    w_req          = 1'b0;
    pe_wb_write_en = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = (cfg_out_w == 8'd0 || cfg_out_h == 8'd0) ? S_DONE : S_WFETCH;
      end
      S_WFETCH: begin
        w_req = 1'b1;
        if (w_valid) w_next = S_WLOAD;
      end
      S_WLOAD: begin
        pe_wb_write_en = 1'b1;
        w_next         = S_STREAM;
      end
      S_STREAM: if (w_accept && w_last) w_next = S_DRAIN;
      S_DRAIN:  if (w_inflight == 32'd0 && r_count == '0) w_next = S_DONE;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_total  <= '0;
      r_addr   <= '0;
      r_cool   <= 1'b0;
      r_filter <= '0;
      r_ifmap  <= '0;
    end else begin
      r_state <= w_next;
      r_cool  <= w_accept;
      if (r_state == S_IDLE && start) begin
        r_total <= 16'(cfg_out_w) * 16'(cfg_out_h);
        r_addr  <= '0;
      end
      if (r_state == S_WFETCH && w_valid) r_filter <= w_data;
      if (w_accept) begin
        r_ifmap <= win_data;
        r_addr  <= r_addr + ADDR_W'(1);
      end
    end
  end

  // Stage 0 lines up with pe_ifmap; the tag at stage PE_LAT meets the matching pe_psum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pipe_vld <= '0;
      for (int i = 0; i <= PE_LAT; i++) r_pipe_idx[i] <= '0;
    end else begin
      r_pipe_vld    <= {r_pipe_vld[PE_LAT-1:0], w_accept};
      r_pipe_idx[0] <= r_addr;
      for (int i = 1; i <= PE_LAT; i++) r_pipe_idx[i] <= r_pipe_idx[i-1];
    end
  end

`ifdef CONV_CTRL_RELU_EN
  always_comb begin
    w_psum = pe_psum;
    for (int i = 0; i < N; i++)
      if (pe_psum[16*i+15]) w_psum[16*i +: 16] = 16'd0;
  end
`else
  assign w_psum = pe_psum;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_dat[r_wr_ptr] <= w_psum;
      r_fifo_idx[r_wr_ptr] <= r_pipe_idx[PE_LAT];
    end
  end

endmodule

// File: tb/tb_conv3x3_pe_ctrl.sv
// Bench for conv3x3_pe_ctrl: random fetch/ready handshakes against a queue of expected results built from out_w*out_h.
// The PE is a PE_LAT-cycle delay of pe_ifmap[15:0], or a fixed negative psum when const_mode is set.
module tb_conv3x3_pe_ctrl;
  localparam int N = 1, PE_LAT = 2, FIFO_DEPTH = 4, ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst, start, w_valid, win_valid, out_ready;
  logic [7:0]        cfg_out_w, cfg_out_h;
  logic [71:0]       w_data, win_data;
  logic              busy, done, w_req, win_req, pe_wb_write_en, out_valid;
  logic [ADDR_W-1:0] win_addr, out_idx;
  logic [71:0]       pe_filter, pe_ifmap;
  logic [15:0]       pe_psum, out_data;
  logic [15:0]       s1, s2;
  logic              const_mode;

  conv3x3_pe_ctrl #(.N(N), .PE_LAT(PE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_out_w(cfg_out_w), .cfg_out_h(cfg_out_h),
    .busy(busy), .done(done), .w_req(w_req), .w_valid(w_valid), .w_data(w_data),
    .win_req(win_req), .win_addr(win_addr), .win_valid(win_valid), .win_data(win_data),
    .pe_wb_write_en(pe_wb_write_en), .pe_filter(pe_filter), .pe_ifmap(pe_ifmap), .pe_psum(pe_psum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    s1 <= pe_ifmap[15:0];
    s2 <= s1;
  end
  assign pe_psum = const_mode ? 16'hFFF0 : s2;

  typedef struct {logic [15:0] d; logic [15:0] idx;} exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int n_acc, n_pop, n_wb, n_done = 0, n_wreq, n_winreq, wb_cyc, first_win_cyc, t_start, done_cyc;
  int rdy_mode;
  logic exp_wb = 1'b0, p_acc = 1'b0, p_hold = 1'b0, p_stall = 1'b0, p_done = 1'b0;
  logic [71:0] p_ifmap, cur_wdata;
  logic [15:0] p_addr, p_odat, p_oidx;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_val(input int a);
    if (const_mode) begin
`ifdef CONV_CTRL_RELU_EN
      return 16'h0000;
`else
      return 16'hFFF0;
`endif
    end
    return 16'(a + 'h100);
  endfunction

  task automatic check_reset_outs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_w_req", w_req, 0);
    check("rst_win_req", win_req, 0);
    check("rst_win_addr", win_addr, 0);
    check("rst_wb_en", pe_wb_write_en, 0);
    check("rst_filter", pe_filter, 0);
    check("rst_ifmap", pe_ifmap, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check("wb_en", pe_wb_write_en, exp_wb);
    if (pe_wb_write_en) begin
      n_wb++;
      wb_cyc = cyc;
      check("filter", pe_filter, cur_wdata);
    end
    if (p_acc) begin
      check("req_drop", win_req, 0);
      check("ifmap", pe_ifmap, p_ifmap);
    end
    if (p_hold) begin
      check("req_hold", win_req, 1);
      check("addr_hold", win_addr, p_addr);
    end
    if (p_stall) begin
      check("stall_vld", out_valid, 1);
      check("stall_dat", out_data, p_odat);
      check("stall_idx", out_idx, p_oidx);
    end
    if (p_done) check("busy_fall", {busy, done}, 2'b00);
    if (done) begin
      n_done++;
      done_cyc = cyc;
      check("done_busy", busy, 1);
      check("done_q_empty", exp_q.size(), 0);
    end
    if (w_req) n_wreq++;
    if (win_req) begin
      n_winreq++;
      if (first_win_cyc == 0) first_win_cyc = cyc;
    end
    exp_wb = 1'b0; p_acc = 1'b0; p_hold = 1'b0; p_stall = 1'b0; p_done = done;
    w_valid = w_req && ($urandom_range(0, 1) == 1);
    w_data  = w_valid ? cur_wdata : {8'($urandom), 32'($urandom), 32'($urandom)};
    exp_wb  = w_valid;
    if (win_req) begin
      win_valid = ($urandom_range(0, 2) != 0);
      win_data  = {24'($urandom), 32'($urandom), 16'(win_addr + 16'h0100)};
      if (win_valid) begin
        check("win_addr_seq", win_addr, n_acc);
        check("credit", (n_acc - n_pop) < FIFO_DEPTH, 1);
        n_acc++;
        p_acc   = 1'b1;
        p_ifmap = win_data;
      end else begin
        p_hold = 1'b1;
        p_addr = win_addr;
      end
    end else begin
      win_valid = ($urandom_range(0, 3) == 0);
      win_data  = '1;
    end
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 1) == 1);
    endcase
    if (out_valid && out_ready) begin
      check("pop_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_idx", out_idx, e.idx);
        check("out_data", out_data, e.d);
      end
      n_pop++;
    end else if (out_valid) begin
      p_stall = 1'b1;
      p_odat  = out_data;
      p_oidx  = out_idx;
    end
  endtask

  task automatic start_job(input int w, input int h, input logic [71:0] wd);
    n_acc = 0; n_pop = 0; n_wb = 0; n_wreq = 0; n_winreq = 0; wb_cyc = 0; first_win_cyc = 0;
    cur_wdata = wd;
    exp_q.delete();
    for (int a = 0; a < w * h; a++) begin
      exp_t e;
      e.d   = exp_val(a);
      e.idx = 16'(a);
      exp_q.push_back(e);
    end
    cfg_out_w = 8'(w);
    cfg_out_h = 8'(h);
    start     = 1'b1;
    t_start   = cyc;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("wreq_after_start", w_req, (w != 0 && h != 0));
  endtask

  task automatic finish_job(input int total, input int d0);
    int budget = 3000;
    while (n_done == d0 && budget > 0) begin
      tick();
      budget--;
    end
    check("done_seen", n_done - d0, 1);
    tick();
    tick();
    check("done_once", n_done - d0, 1);
    check("accepted", n_acc, total);
    check("popped", n_pop, total);
    check("q_empty", exp_q.size(), 0);
    check("wb_pulses", n_wb, (total > 0) ? 1 : 0);
    check("busy_idle", busy, 0);
    if (total > 0) check("win_after_wload", first_win_cyc > wb_cyc, 1);
  endtask

  initial begin
    int d0, budget;
    logic [71:0] wd0;
    rst = 1'b0; start = 1'b0; w_valid = 1'b0; win_valid = 1'b0; out_ready = 1'b0;
    cfg_out_w = 8'd0; cfg_out_h = 8'd0; w_data = '0; win_data = '0;
    const_mode = 1'b0; rdy_mode = 1;
    repeat (3) @(negedge clk);
    check_reset_outs();
    rst = 1'b1;
    tick();
    check_reset_outs();

    wd0 = 72'h010000000100000001;
    d0 = n_done;
    start_job(1, 1, wd0);
    finish_job(1, d0);

    d0 = n_done;
    start_job(0, 5, wd0);
    finish_job(0, d0);
    check("zero_done_lat", (done_cyc - t_start) >= 1 && (done_cyc - t_start) <= 2, 1);
    check("zero_no_wreq", n_wreq, 0);
    check("zero_no_winreq", n_winreq, 0);
    check("filter_persist", pe_filter, wd0);

    d0 = n_done;
    start_job(3, 2, {8'($urandom), 32'($urandom), 32'($urandom)});
    finish_job(6, d0);

    rdy_mode = 0;
    d0 = n_done;
    start_job(4, 4, {8'($urandom), 32'($urandom), 32'($urandom)});
    repeat (80) tick();
    check("bp_accepted", n_acc, FIFO_DEPTH);
    check("bp_req_low", win_req, 0);
    check("bp_no_done", n_done - d0, 0);
    rdy_mode = 2;
    finish_job(16, d0);

    for (int j = 0; j < 4; j++) begin
      int w, h;
      w = $urandom_range(1, 5);
      h = $urandom_range(1, 4);
      d0 = n_done;
      start_job(w, h, {8'($urandom), 32'($urandom), 32'($urandom)});
      finish_job(w * h, d0);
    end

    d0 = n_done;
    start_job(8, 8, {8'($urandom), 32'($urandom), 32'($urandom)});
    budget = 500;
    while (n_acc < 5 && budget > 0) begin
      tick();
      budget--;
    end
    check("mid_stream_reached", n_acc >= 5, 1);
    rst = 1'b0;
    #1;
    check_reset_outs();
    exp_wb = 1'b0; p_acc = 1'b0; p_hold = 1'b0; p_stall = 1'b0; p_done = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("abort_no_done", n_done - d0, 0);
    check("abort_idle", busy, 0);
    rdy_mode = 1;
    d0 = n_done;
    start_job(1, 1, {8'($urandom), 32'($urandom), 32'($urandom)});
    finish_job(1, d0);

    const_mode = 1'b1;
    rdy_mode = 2;
    d0 = n_done;
    start_job(2, 2, {8'($urandom), 32'($urandom), 32'($urandom)});
    finish_job(4, d0);
    const_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
